// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the router destination-side packet reader.
//   Packet format: header = {len[5:0], addr[1:0]}, len payload bytes, then one
//   parity byte equal to the XOR of the header and every payload byte.
//   Contents:
//     - header field positions, address width, maximum payload length
//     - beat_t : one byte plus its sop/eop/err tags as presented to the client
//     - helpers to pull fields out of a header and to check parity
// ----------------------------------------------------------------------------
package router_pkg;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int ADDR_W      = 2;
  localparam int MAX_LEN     = 63;
  localparam int LEN_W       = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  // Payload length field of a header byte.
  function automatic logic [LEN_W-1:0] hdr_len_of(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  // Destination address field of a header byte.
  function automatic logic [ADDR_W-1:0] hdr_addr_of(input logic [7:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

  // True when the received parity byte disagrees with the running XOR.
  function automatic logic parity_mismatch(input logic [7:0] acc,
                                           input logic [7:0] par);
    return ((acc ^ par) != 8'h00);
  endfunction

endpackage

// File: rtl/router_rd_skid.sv
// ----------------------------------------------------------------------------
// router_rd_skid
//   Two-entry beat buffer between the FIFO capture stage and the client
//   stream. The head entry is held in registers and drives the client
//   outputs directly, so the presented beat is stable while stalled.
//   Ports:
//     clock, resetn   : system clock, synchronous active-low reset
//     flush_i         : synchronous flush (empties the buffer)
//     push_valid_i    : write push_beat_i this cycle
//     push_beat_i     : beat to store
//     pop_ready_i     : client ready; a pop happens on head_valid_o && ready
//     head_valid_o    : head entry valid
//     head_beat_o     : head entry contents
//     occ_o           : number of stored beats (0..2)
//   The upstream credit check guarantees a push never meets a full buffer
//   unless a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module router_rd_skid
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       flush_i,
  input  logic       push_valid_i,
  input  beat_t      push_beat_i,
  input  logic       pop_ready_i,
  output logic       head_valid_o,
  output beat_t      head_beat_o,
  output logic [1:0] occ_o
);

  beat_t      e0_q, e0_d;
  beat_t      e1_q, e1_d;
  logic [1:0] occ_q, occ_d;
  logic       valid_q, valid_d;
  logic       pop_s;

  assign pop_s = valid_q && pop_ready_i;

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case (occ_q)
      2'd0: begin
        if (push_valid_i) begin
          e0_d  = push_beat_i;
          occ_d = 2'd1;
        end else begin
          occ_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_valid_i && pop_s) begin
          e0_d = push_beat_i;
        end else if (push_valid_i) begin
          e1_d  = push_beat_i;
          occ_d = 2'd2;
        end else if (pop_s) begin
          occ_d = 2'd0;
        end else begin
          occ_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          e0_d = e1_q;
          if (push_valid_i) begin
            e1_d = push_beat_i;
          end else begin
            occ_d = 2'd1;
          end
        end else begin
          occ_d = 2'd2;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
    valid_d = (occ_d != 2'd0);
  end

  // Buffer state registers; reset and flush both empty the buffer.
  always_ff @(posedge clock) begin
    if (!resetn || flush_i) begin
      e0_q    <= '0;
      e1_q    <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign head_valid_o = valid_q;
  assign head_beat_o  = e0_q;
  assign occ_o        = occ_q;

endmodule

// File: rtl/router_pkt_reader.sv
// ----------------------------------------------------------------------------
// router_pkt_reader
//   Destination-side consumer for one router output FIFO. Issues read_enb,
//   captures the byte returned one cycle later, tags it as header / payload /
//   parity, checks parity and hands each byte to the client on a valid/ready
//   stream through a two-entry buffer.
//   Ports:
//     clock, resetn          : system clock, synchronous active-low reset
//     soft_reset             : synchronous flush, aligned with the FIFO flush
//     fifo_empty, fifo_data  : FIFO status and registered read data
//     read_enb               : FIFO read strobe (combinational)
//     pkt_data/valid/ready   : client byte stream
//     pkt_sop, pkt_eop       : header / parity beat tags
//     pkt_err                : parity mismatch, meaningful with pkt_eop
//     hdr_addr               : address of the last captured header
//     pkt_cnt, err_cnt       : saturating packet / parity-error counters
//   Parameters:
//     CNT_W     : statistics counter width
//     BUF_DEPTH : output buffer depth, only 2 is supported
// ----------------------------------------------------------------------------
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_data,
  output logic              read_enb,
  output logic [7:0]        pkt_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic              pkt_err,
  output logic [ADDR_W-1:0] hdr_addr,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [2:0] CREDIT_LIMIT = 3'(BUF_DEPTH);

  logic              inflight_q;
  logic [6:0]        iss_cnt_q, iss_cnt_d;
  logic [6:0]        cap_cnt_q, cap_cnt_d;
  logic [LEN_W-1:0]  hdr_len_q, hdr_len_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
  logic [7:0]        acc_q, acc_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              head_valid_s;
  beat_t             head_beat_s;
  logic [1:0]        occ_s;
  logic              pop_s;
  logic [2:0]        credit_s;
  logic [LEN_W-1:0]  len_eff_s;
  logic              issue_ok_s;
  logic              iss_last_s;
  logic              read_enb_s;
  beat_t             cap_beat_s;

  // ---------------------------------------------------------------- issue
  // A beat leaving the buffer this cycle frees its slot in time for the byte
  // read now, which lands two edges later; this keeps 1 byte/cycle streaming.
  assign pop_s    = head_valid_s && pkt_ready;
  assign credit_s = {1'b0, occ_s} - {2'b00, pop_s} + {2'b00, inflight_q};

  // The second read of a packet coincides with the header capture, so the
  // length is taken straight from fifo_data in that one cycle.
  assign len_eff_s = (inflight_q && (cap_cnt_q == 7'd0)) ? hdr_len_of(fifo_data)
                                                         : hdr_len_q;

  assign issue_ok_s = (iss_cnt_q < 7'd2) ? 1'b1
                                         : (iss_cnt_q < ({1'b0, hdr_len_q} + 7'd2));

  // The read that brings the count to len+2 fetches the parity byte.
  assign iss_last_s = ((iss_cnt_q + 7'd1) == ({1'b0, len_eff_s} + 7'd2));

  assign read_enb_s = !fifo_empty && !soft_reset && resetn &&
                      (credit_s < CREDIT_LIMIT) && issue_ok_s;
  assign read_enb   = read_enb_s;

  // Per-packet issue counter; wraps after the parity read so the next read
  // is the following header.
  always_comb begin
    if (read_enb_s) begin
      if (iss_last_s) begin
        iss_cnt_d = 7'd0;
      end else begin
        iss_cnt_d = iss_cnt_q + 7'd1;
      end
    end else begin
      iss_cnt_d = iss_cnt_q;
    end
  end

  // -------------------------------------------------------------- capture
  // Tag the returning byte, run the parity XOR and update statistics.
  always_comb begin
    cap_cnt_d       = cap_cnt_q;
    hdr_len_d       = hdr_len_q;
    hdr_addr_d      = hdr_addr_q;
    acc_d           = acc_q;
    pkt_cnt_d       = pkt_cnt_q;
    err_cnt_d       = err_cnt_q;
    cap_beat_s.data = fifo_data;
    cap_beat_s.sop  = 1'b0;
    cap_beat_s.eop  = 1'b0;
    cap_beat_s.err  = 1'b0;
    if (inflight_q) begin
      if (cap_cnt_q == 7'd0) begin
        cap_beat_s.sop = 1'b1;
        hdr_len_d      = hdr_len_of(fifo_data);
        hdr_addr_d     = hdr_addr_of(fifo_data);
        acc_d          = fifo_data;
        cap_cnt_d      = 7'd1;
      end else if (cap_cnt_q <= {1'b0, hdr_len_q}) begin
        acc_d     = acc_q ^ fifo_data;
        cap_cnt_d = cap_cnt_q + 7'd1;
      end else begin
        cap_beat_s.eop = 1'b1;
        cap_beat_s.err = parity_mismatch(acc_q, fifo_data);
        cap_cnt_d      = 7'd0;
        if (&pkt_cnt_q) begin
          pkt_cnt_d = pkt_cnt_q;
        end else begin
          pkt_cnt_d = pkt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (cap_beat_s.err && !(&err_cnt_q)) begin
          err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
    end else begin
      cap_cnt_d = cap_cnt_q;
    end
  end

  // Parser state; soft_reset drops the packet in progress but keeps the
  // address and statistics.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      inflight_q <= 1'b0;
      iss_cnt_q  <= 7'd0;
      cap_cnt_q  <= 7'd0;
      hdr_len_q  <= '0;
      hdr_addr_q <= '0;
      acc_q      <= 8'h00;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else if (soft_reset) begin
      inflight_q <= 1'b0;
      iss_cnt_q  <= 7'd0;
      cap_cnt_q  <= 7'd0;
      hdr_len_q  <= '0;
      hdr_addr_q <= hdr_addr_q;
      acc_q      <= 8'h00;
      pkt_cnt_q  <= pkt_cnt_q;
      err_cnt_q  <= err_cnt_q;
    end else begin
      inflight_q <= read_enb_s;
      iss_cnt_q  <= iss_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      hdr_len_q  <= hdr_len_d;
      hdr_addr_q <= hdr_addr_d;
      acc_q      <= acc_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // --------------------------------------------------------------- output
  router_rd_skid u_skid (
    .clock        (clock),
    .resetn       (resetn),
    .flush_i      (soft_reset),
    .push_valid_i (inflight_q),
    .push_beat_i  (cap_beat_s),
    .pop_ready_i  (pkt_ready),
    .head_valid_o (head_valid_s),
    .head_beat_o  (head_beat_s),
    .occ_o        (occ_s)
  );

  assign pkt_valid = head_valid_s;
  assign pkt_data  = head_beat_s.data;
  assign pkt_sop   = head_beat_s.sop;
  assign pkt_eop   = head_beat_s.eop;
  assign pkt_err   = head_beat_s.err;
  assign hdr_addr  = hdr_addr_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/router_pkt_reader.md
Name: router_pkt_reader

Overview:
- Destination-side consumer for one router output FIFO (16 x 9-bit).
- Drains the FIFO with read_enb and parses the router packet format.
- Packet format: header byte = {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte. Parity = XOR of the header and all payload bytes.
- Presents each byte to the client on a valid/ready stream with sop/eop tags, checks parity, and keeps packet and error statistics.

Parameters:
- CNT_W, 16, width of the saturating statistics counters.
- BUF_DEPTH, 2, output buffer entries. Fixed at 2; any other value is unsupported.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- soft_reset  in  1  synchronous flush from the router sync block, same cycle as the FIFO flush.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO data_out. Registered in the FIFO: valid the cycle after read_enb.
- read_enb  out  1  FIFO read strobe.
- pkt_data  out  8  byte presented to the client.
- pkt_valid  out  1  pkt_data is valid.
- pkt_ready  in  1  client accepts the beat when pkt_valid && pkt_ready.
- pkt_sop  out  1  current beat is a header.
- pkt_eop  out  1  current beat is a parity byte.
- pkt_err  out  1  parity mismatch. Meaningful only when pkt_eop=1.
- hdr_addr  out  2  addr field of the last captured header.
- pkt_cnt  out  CNT_W  number of packets completed, saturating.
- err_cnt  out  CNT_W  number of parity errors, saturating.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_data, hdr_addr, pkt_cnt and err_cnt all go to 0.
  - Buffer is emptied; in-flight flag and both byte counters are cleared.
- read_enb is combinational: read_enb = !fifo_empty && !soft_reset && resetn && (buf_occ + inflight < 2) && issue_ok.
  - inflight is read_enb registered.
  - read_enb is never asserted while fifo_empty=1.
- Issue side:
  - iss_cnt (7 bits) counts reads issued for the current packet.
  - While iss_cnt < 2: issue_ok=1. Every packet has at least a header and a parity byte.
  - While iss_cnt >= 2: issue_ok = (iss_cnt < hdr_len+2). hdr_len is guaranteed to be latched by then.
  - When the issued read is byte number hdr_len+2, iss_cnt returns to 0. The next read is the next header, so back-to-back packets have no idle cycle.
- Capture side:
  - When inflight=1, fifo_data is written into the buffer along with tags.
  - cap_cnt == 0 marks a header: set sop, latch hdr_len=data[7:2] and hdr_addr=data[1:0], and set parity accumulator = data.
  - 0 < cap_cnt <= hdr_len marks a payload byte: accumulator ^= data.
  - cap_cnt == hdr_len+1 marks the parity byte: set eop, err = (accumulator != data), then cap_cnt returns to 0.
  - When hdr_len=0, the header is followed directly by the parity byte (two beats total).
- Statistics:
  - On parity capture, pkt_cnt increments by 1.
  - On parity capture with err=1, err_cnt also increments.
  - Both counters saturate at all-ones.
- Output buffer:
  - 2-entry FIFO of {data, sop, eop, err}. Head entry drives the pkt_* outputs.
  - Hold rule: pkt_* stay stable while pkt_valid && !pkt_ready.
  - Simultaneous push and pop in one cycle keeps occupancy unchanged.
  - Overflow is impossible by the credit rule.
- Latency: read_enb in cycle T, fifo_data valid in T+1, pkt_valid in T+2. With pkt_ready held high, throughput is 1 byte/cycle.
- soft_reset=1 (when resetn=1):
  - Next cycle: buffer emptied, pkt_valid=0, inflight=0, iss_cnt=cap_cnt=0, accumulator=0.
  - hdr_addr, pkt_cnt and err_cnt are held.
  - The in-flight byte is discarded.
  - The next byte read is treated as a header.
- Reset or soft_reset mid-packet produces no eop beat and no counter increment.

Decomposition:
- Package router_pkg:
  - HDR_LEN_MSB=7, HDR_LEN_LSB=2, ADDR_W=2, MAX_LEN=63.
  - Beat typedef {data[7:0], sop, eop, err}.
- Sub-module router_rd_skid: 2-entry beat buffer with valid/ready, occupancy output and synchronous flush.

Test Plan:
- Header 0x0D (len 3, addr 1), payload 0x11, 0x22, 0x33, parity 0x0D, ready=1 -> 5 beats in order. sop on beat 0 only, eop on beat 4 only, err=0, hdr_addr=1, pkt_cnt=1. read_enb high exactly 5 cycles; first pkt_valid 2 cycles after first read_enb.
- Same packet with parity 0x0C -> eop beat has err=1; err_cnt=1, pkt_cnt=1.
- Header 0x02 (len 0, addr 2), parity 0x02 -> 2 beats: sop then eop, err=0.
- Header 0x0D packet, pkt_ready=0 for 10 cycles after beat 1 -> at most 2 bytes buffered, read_enb low while buffer full. No loss or reorder; pkt_data held stable while stalled.
- Two back-to-back packets (0x05/0xAA/0xAF, then 0x06/0x55/0x53) with ready=1 -> second sop immediately follows first eop, both err=0, pkt_cnt=2.
- soft_reset pulse after beat 2 of a len-3 packet -> pkt_valid=0 next cycle, no eop, pkt_cnt unchanged. Next packet 0x05/0xAA/0xAF parses correctly. A resetn pulse mid-packet clears all outputs and counters to 0.
